// File: rtl/mp_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mp_arb_pkg
// Purpose  : Shared types and width helpers for the multi-precision adder
//            arbiter: FSM state encoding, requester-ID width and watchdog
//            counter width.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package mp_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    // Bits needed to hold values 0..value-1, never less than one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 2) ? 1 : $clog2(value);
    endfunction

    // Requester-ID width for a given requester count.
    function automatic int id_width(input int n_req);
        return clog2_min1(n_req);
    endfunction

    // Watchdog counts 0..timeout-1, so it needs clog2(timeout) bits.
    function automatic int wd_width(input int timeout_cycles);
        return clog2_min1(timeout_cycles);
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Purpose  : Combinational round-robin pick. Scans the request vector upward
//            starting at iPtr, wrapping modulo N_REQ, and reports the first
//            set bit. Usable for any shared datapath resource.
// Ports    : iReq   - request vector
//            iPtr   - index with highest priority this cycle (< N_REQ)
//            oValid - at least one request present
//            oGnt   - one-hot winner
//            oIdx   - encoded winner
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic [N_REQ-1:0] iReq,
    input  logic [ID_W-1:0]  iPtr,
    output logic             oValid,
    output logic [N_REQ-1:0] oGnt,
    output logic [ID_W-1:0]  oIdx
);

    logic [N_REQ-1:0] w_rot;
    logic [ID_W-1:0]  w_off;

    always_comb begin
        // Rotate so that requester iPtr sits at bit 0; the first set bit of
        // the rotated vector is then the offset from the pointer.
        w_rot  = N_REQ'({iReq, iReq} >> iPtr);
        w_off  = '0;
        oValid = 1'b0;
        for (int j = 0; j < N_REQ; j++) begin
            if (!oValid && w_rot[j]) begin
                oValid = 1'b1;
                w_off  = ID_W'(j);
            end
        end

        // Undo the rotation modulo N_REQ. The comparison is done one bit
        // wider so the sum cannot overflow before the wrap test.
        if (({1'b0, iPtr} + {1'b0, w_off}) >= (ID_W + 1)'(N_REQ)) begin
            oIdx = iPtr + w_off - ID_W'(N_REQ);
        end else begin
            oIdx = iPtr + w_off;
        end

        oGnt = '0;
        for (int j = 0; j < N_REQ; j++) begin
            oGnt[j] = oValid && (oIdx == ID_W'(j));
        end
    end

endmodule
`default_nettype wire

// File: rtl/mp_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mp_adder_arbiter
// Purpose  : Shares one multi-precision adder among N_REQ requesters.
//            Round-robin pick in IDLE, start pulse in START, wait for the
//            adder's done (guarded by a watchdog) in WAIT, and hold the
//            response on a valid/ready channel in RESP. One job in flight.
// Ports    : iClk/iRstn          - clock, synchronous active-low reset
//            iReq, iOpA, iOpB    - per-requester level request and operands
//            oGnt                - one-hot grant pulse (START cycle)
//            oAddStart/OpA/OpB   - adder start pulse and latched operands
//            iAddRes/iAddDone    - adder result and completion
//            oRspValid/Id/Res    - response channel, iRspReady backpressure
//            oTimeout            - sticky watchdog flag
// Revision : 1.0 - initial release
// ============================================================================
module mp_adder_arbiter
    import mp_arb_pkg::*;
#(
    parameter int N_REQ          = 4,
    parameter int OPERAND_WIDTH  = 512,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int ID_W           = id_width(N_REQ)
) (
    input  logic                         iClk,
    input  logic                         iRstn,
    input  logic [N_REQ-1:0]             iReq,
    input  logic [N_REQ*OPERAND_WIDTH-1:0] iOpA,
    input  logic [N_REQ*OPERAND_WIDTH-1:0] iOpB,
    output logic [N_REQ-1:0]             oGnt,
    output logic                         oAddStart,
    output logic [OPERAND_WIDTH-1:0]     oAddOpA,
    output logic [OPERAND_WIDTH-1:0]     oAddOpB,
    input  logic [OPERAND_WIDTH:0]       iAddRes,
    input  logic                         iAddDone,
    output logic                         oRspValid,
    output logic [ID_W-1:0]              oRspId,
    output logic [OPERAND_WIDTH:0]       oRspRes,
    input  logic                         iRspReady,
    output logic                         oTimeout
);

    localparam int              WD_W       = wd_width(TIMEOUT_CYCLES);
    localparam logic [WD_W-1:0] c_wd_limit = WD_W'(TIMEOUT_CYCLES - 1);
    localparam logic [ID_W-1:0] c_last_id  = ID_W'(N_REQ - 1);

    state_t                   r_state;
    logic [ID_W-1:0]          r_ptr;
    logic [WD_W-1:0]          r_wd;
    logic [N_REQ-1:0]         r_gnt;
    logic                     r_start;
    logic [OPERAND_WIDTH-1:0] r_opa;
    logic [OPERAND_WIDTH-1:0] r_opb;
    logic                     r_rsp_valid;
    logic [ID_W-1:0]          r_rsp_id;
    logic [OPERAND_WIDTH:0]   r_rsp_res;
    logic                     r_timeout;

    logic                     w_any;
    logic [N_REQ-1:0]         w_win_oh;
    logic [ID_W-1:0]          w_win;
    logic [ID_W-1:0]          w_ptr_next;
    logic [OPERAND_WIDTH-1:0] w_sel_a;
    logic [OPERAND_WIDTH-1:0] w_sel_b;

    rr_arbiter #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_rr (
        .iReq   (iReq),
        .iPtr   (r_ptr),
        .oValid (w_any),
        .oGnt   (w_win_oh),
        .oIdx   (w_win)
    );

    // Operand slice of the winner; the one-hot grant drives the mux directly.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int j = 0; j < N_REQ; j++) begin
            if (w_win_oh[j]) begin
                w_sel_a = iOpA[j*OPERAND_WIDTH +: OPERAND_WIDTH];
                w_sel_b = iOpB[j*OPERAND_WIDTH +: OPERAND_WIDTH];
            end
        end
    end

    // The requester after the winner gets top priority next time.
    assign w_ptr_next = (w_win == c_last_id) ? '0 : w_win + ID_W'(1);

    always_ff @(posedge iClk) begin
        if (!iRstn) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_wd        <= '0;
            r_gnt       <= '0;
            r_start     <= 1'b0;
            r_opa       <= '0;
            r_opb       <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_res   <= '0;
            r_timeout   <= 1'b0;
        end else begin
            // Grant and start are single-cycle pulses covering START only.
            r_gnt   <= '0;
            r_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_opa    <= w_sel_a;
                        r_opb    <= w_sel_b;
                        r_rsp_id <= w_win;
                        r_ptr    <= w_ptr_next;
                        r_gnt    <= w_win_oh;
                        r_start  <= 1'b1;
                        r_state  <= ST_START;
                    end
                end
                ST_START: begin
                    r_wd    <= '0;
                    r_state <= ST_WAIT;
                end
                ST_WAIT: begin
                    // Done takes priority over an expiring watchdog.
                    if (iAddDone) begin
                        r_rsp_res   <= iAddRes;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else if (r_wd == c_wd_limit) begin
                        r_timeout   <= 1'b1;
                        r_rsp_res   <= '0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_wd <= r_wd + WD_W'(1);
                    end
                end
                ST_RESP: begin
                    if (iRspReady) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign oGnt      = r_gnt;
    assign oAddStart = r_start;
    assign oAddOpA   = r_opa;
    assign oAddOpB   = r_opb;
    assign oRspValid = r_rsp_valid;
    assign oRspId    = r_rsp_id;
    assign oRspRes   = r_rsp_res;
    assign oTimeout  = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_mp_adder_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mp_adder_arbiter
// Purpose  : Directed self-checking bench for mp_adder_arbiter with a small
//            behavioural adder (fixed latency, can be made to never finish).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mp_adder_arbiter;

    localparam int N   = 4;
    localparam int OW  = 512;
    localparam int TO  = 64;
    localparam int IDW = 2;
    localparam int ADD_LAT = 3;

    logic            clk = 1'b0;
    logic            rstn;
    logic [N-1:0]    req;
    logic [N*OW-1:0] opa;
    logic [N*OW-1:0] opb;
    logic [N-1:0]    gnt;
    logic            add_start;
    logic [OW-1:0]   add_opa;
    logic [OW-1:0]   add_opb;
    logic [OW:0]     add_res;
    logic            add_done;
    logic            rsp_valid;
    logic [IDW-1:0]  rsp_id;
    logic [OW:0]     rsp_res;
    logic            rsp_ready;
    logic            timeout;

    int n_cmp = 0;
    int n_bad = 0;

    bit add_dead = 1'b0;
    int add_cnt;

    always #5 clk = ~clk;

    mp_adder_arbiter #(
        .N_REQ          (N),
        .OPERAND_WIDTH  (OW),
        .TIMEOUT_CYCLES (TO),
        .ID_W           (IDW)
    ) dut (
        .iClk      (clk),
        .iRstn     (rstn),
        .iReq      (req),
        .iOpA      (opa),
        .iOpB      (opb),
        .oGnt      (gnt),
        .oAddStart (add_start),
        .oAddOpA   (add_opa),
        .oAddOpB   (add_opb),
        .iAddRes   (add_res),
        .iAddDone  (add_done),
        .oRspValid (rsp_valid),
        .oRspId    (rsp_id),
        .oRspRes   (rsp_res),
        .iRspReady (rsp_ready),
        .oTimeout  (timeout)
    );

    // Behavioural adder: done pulses ADD_LAT cycles after start.
    always @(posedge clk) begin
        if (!rstn) begin
            add_cnt  <= 0;
            add_done <= 1'b0;
            add_res  <= '0;
        end else begin
            add_done <= 1'b0;
            if (add_start) begin
                add_cnt <= ADD_LAT;
            end else if (add_cnt > 0) begin
                add_cnt <= add_cnt - 1;
                if (add_cnt == 1 && !add_dead) begin
                    add_done <= 1'b1;
                    add_res  <= {1'b0, add_opa} + {1'b0, add_opb};
                end
            end
        end
    end

    task automatic set_ops(input int i, input logic [OW-1:0] a, input logic [OW-1:0] b);
        opa[i*OW +: OW] = a;
        opb[i*OW +: OW] = b;
    endtask

    task automatic wait_gnt(output logic [N-1:0] g, output bit ok);
        ok = 1'b0;
        g  = '0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (gnt != '0) begin
                g  = gnt;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_rsp(output int cycles, output bit ok);
        ok     = 1'b0;
        cycles = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                cycles = c;
                ok     = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        req = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (gnt !== 4'b0000 || add_start !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_gnt_start: got gnt=%b start=%b want 0000/0", gnt, add_start);
        end
        n_cmp++;
        if (rsp_valid !== 1'b0 || timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_valid_timeout: got valid=%b timeout=%b want 0/0", rsp_valid, timeout);
        end
        n_cmp++;
        if (add_opa !== '0 || add_opb !== '0 || rsp_id !== '0 || rsp_res !== '0) begin
            n_bad++;
            $display("FAIL reset_data: got id=%0d res=%h want 0/0 (operands zero expected)", rsp_id, rsp_res);
        end
        rstn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_round_robin();
        logic [OW:0] exp;
        int cyc;
        bit ok;
        for (int i = 0; i < N; i++) set_ops(i, OW'(i), OW'(10 * i));
        rsp_ready = 1'b1;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            wait_rsp(cyc, ok);
            exp = (OW + 1)'(11 * (k % 4));
            n_cmp++;
            if (!ok || rsp_id !== IDW'(k % 4)) begin
                n_bad++;
                $display("FAIL rr_id[%0d]: got %0d want %0d (seen=%0d)", k, rsp_id, k % 4, ok);
            end
            n_cmp++;
            if (!ok || rsp_res !== exp) begin
                n_bad++;
                $display("FAIL rr_res[%0d]: got %h want %h", k, rsp_res, exp);
            end
        end
        req = '0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_single();
        logic [N-1:0] g;
        logic [OW:0]  exp;
        int cyc;
        bit ok;
        rsp_ready = 1'b0;
        set_ops(1, {OW{1'b1}}, OW'(1));
        req = 4'b0010;
        wait_gnt(g, ok);
        n_cmp++;
        if (!ok || g !== 4'b0010) begin
            n_bad++;
            $display("FAIL single_gnt: got %b want 0010 (seen=%0d)", g, ok);
        end
        n_cmp++;
        if (add_start !== 1'b1) begin
            n_bad++;
            $display("FAIL single_start: got %b want 1", add_start);
        end
        req = '0;
        wait_rsp(cyc, ok);
        exp = '0;
        exp[OW] = 1'b1;
        n_cmp++;
        if (!ok || rsp_id !== 2'd1) begin
            n_bad++;
            $display("FAIL single_id: got %0d want 1 (seen=%0d)", rsp_id, ok);
        end
        n_cmp++;
        if (rsp_res !== exp) begin
            n_bad++;
            $display("FAIL single_res: got %h want %h", rsp_res, exp);
        end
        n_cmp++;
        if (timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL single_timeout: got %b want 0", timeout);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL single_drop_valid: got %b want 0", rsp_valid);
        end
    endtask

    task automatic test_back_pressure();
        logic [N-1:0] g;
        int cyc;
        bit ok;
        int bad_cycles;
        rsp_ready = 1'b0;
        set_ops(2, OW'(5), OW'(7));
        set_ops(0, OW'(100), OW'(23));
        req = 4'b0100;
        wait_gnt(g, ok);
        n_cmp++;
        if (!ok || g !== 4'b0100) begin
            n_bad++;
            $display("FAIL bp_gnt: got %b want 0100 (seen=%0d)", g, ok);
        end
        // Requester 0 now waits through the whole job and the stalled response.
        req = 4'b0001;
        wait_rsp(cyc, ok);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL bp_rsp: got no response want valid");
        end
        bad_cycles = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_res !== 513'd12 ||
                gnt !== 4'b0000 || add_start !== 1'b0) begin
                bad_cycles++;
            end
        end
        n_cmp++;
        if (bad_cycles !== 0) begin
            n_bad++;
            $display("FAIL bp_stable: got %0d unstable cycles want 0 (valid=%b id=%0d res=%h)",
                     bad_cycles, rsp_valid, rsp_id, rsp_res);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || gnt !== 4'b0000) begin
            n_bad++;
            $display("FAIL bp_release: got valid=%b gnt=%b want 0/0000", rsp_valid, gnt);
        end
        @(negedge clk);
        n_cmp++;
        if (gnt !== 4'b0001 || add_start !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_next_gnt: got gnt=%b start=%b want 0001/1", gnt, add_start);
        end
        req = '0;
        wait_rsp(cyc, ok);
        n_cmp++;
        if (!ok || rsp_id !== 2'd0 || rsp_res !== 513'd123) begin
            n_bad++;
            $display("FAIL bp_next_rsp: got id=%0d res=%h want 0/7b (seen=%0d)", rsp_id, rsp_res, ok);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_pointer_wrap();
        logic [N-1:0] g;
        int cyc;
        bit ok;
        rsp_ready = 1'b1;
        set_ops(3, OW'(1), OW'(2));
        req = 4'b1000;
        wait_gnt(g, ok);
        n_cmp++;
        if (!ok || g !== 4'b1000) begin
            n_bad++;
            $display("FAIL wrap_gnt3: got %b want 1000", g);
        end
        req = 4'b1001;
        wait_gnt(g, ok);
        n_cmp++;
        if (!ok || g !== 4'b0001) begin
            n_bad++;
            $display("FAIL wrap_gnt0: got %b want 0001", g);
        end
        wait_gnt(g, ok);
        n_cmp++;
        if (!ok || g !== 4'b1000) begin
            n_bad++;
            $display("FAIL wrap_gnt3b: got %b want 1000", g);
        end
        req = '0;
        wait_rsp(cyc, ok);
        n_cmp++;
        if (!ok || rsp_id !== 2'd3 || rsp_res !== 513'd3) begin
            n_bad++;
            $display("FAIL wrap_rsp: got id=%0d res=%h want 3/3", rsp_id, rsp_res);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_timeout();
        logic [N-1:0] g;
        int cyc;
        bit ok;
        rsp_ready = 1'b0;
        add_dead = 1'b1;
        req = 4'b0001;
        wait_gnt(g, ok);
        n_cmp++;
        if (!ok || g !== 4'b0001) begin
            n_bad++;
            $display("FAIL to_gnt: got %b want 0001", g);
        end
        req = '0;
        wait_rsp(cyc, ok);
        n_cmp++;
        if (!ok || cyc !== 65) begin
            n_bad++;
            $display("FAIL to_latency: got %0d cycles want 65 (seen=%0d)", cyc, ok);
        end
        n_cmp++;
        if (timeout !== 1'b1 || rsp_res !== '0 || rsp_id !== 2'd0) begin
            n_bad++;
            $display("FAIL to_rsp: got timeout=%b id=%0d res=%h want 1/0/0", timeout, rsp_id, rsp_res);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        add_dead = 1'b0;
        set_ops(1, OW'(3), OW'(4));
        req = 4'b0010;
        wait_gnt(g, ok);
        req = '0;
        wait_rsp(cyc, ok);
        n_cmp++;
        if (!ok || rsp_res !== 513'd7 || rsp_id !== 2'd1) begin
            n_bad++;
            $display("FAIL to_after_res: got id=%0d res=%h want 1/7 (seen=%0d)", rsp_id, rsp_res, ok);
        end
        n_cmp++;
        if (timeout !== 1'b1) begin
            n_bad++;
            $display("FAIL to_sticky: got %b want 1", timeout);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_job();
        logic [N-1:0] g;
        int cyc;
        bit ok;
        rsp_ready = 1'b0;
        req = 4'b0100;
        wait_gnt(g, ok);
        n_cmp++;
        if (!ok || g !== 4'b0100) begin
            n_bad++;
            $display("FAIL rst_mid_gnt: got %b want 0100", g);
        end
        req = '0;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        n_cmp++;
        if (gnt !== '0 || add_start !== 1'b0 || add_opa !== '0 || add_opb !== '0 ||
            rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_res !== '0 || timeout !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_mid_outputs: got gnt=%b start=%b valid=%b id=%0d timeout=%b want all 0",
                     gnt, add_start, rsp_valid, rsp_id, timeout);
        end
        req = 4'b1001;
        wait_gnt(g, ok);
        n_cmp++;
        if (!ok || g !== 4'b0001) begin
            n_bad++;
            $display("FAIL rst_mid_ptr: got %b want 0001", g);
        end
        req = '0;
        rsp_ready = 1'b1;
        wait_rsp(cyc, ok);
        n_cmp++;
        if (!ok || rsp_id !== 2'd0 || rsp_res !== 513'd123) begin
            n_bad++;
            $display("FAIL rst_mid_rsp: got id=%0d res=%h want 0/7b", rsp_id, rsp_res);
        end
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rstn = 1'b0;
        req = '0;
        opa = '0;
        opb = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_round_robin();
        test_single();
        test_back_pressure();
        test_pointer_wrap();
        test_timeout();
        test_reset_mid_job();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion want finish before 500000");
        $fatal(1, "bench time limit");
    end

endmodule
`default_nettype wire

// File: doc/mp_adder_arbiter.md
Name: mp_adder_arbiter

Overview:
- Shares one multi-precision adder (mp_adder, operand width OPERAND_WIDTH, result OPERAND_WIDTH+1 bits) among N_REQ requesters.
- Round-robin arbitration picks one requester and latches its operands.
- Sequences the adder's start/done protocol and returns the sum with the requester ID over a valid/ready response channel.
- A watchdog flags an adder that never signals done.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- OPERAND_WIDTH, 512, operand width; must match the adder instance.
- TIMEOUT_CYCLES, 64, maximum cycles in WAIT before the job is aborted (must exceed adder latency).
- ID_W, max(1,$clog2(N_REQ)), derived requester-ID width.

Ports:
- iClk  in  1  clock.
- iRstn  in  1  synchronous active-low reset.
- iReq  in  N_REQ  level request per requester.
- iOpA  in  N_REQ*OPERAND_WIDTH  flattened operand A; slice i belongs to requester i.
- iOpB  in  N_REQ*OPERAND_WIDTH  flattened operand B, same layout.
- oGnt  out  N_REQ  one-hot, one-cycle grant pulse.
- oAddStart  out  1  start pulse to the adder's iStart.
- oAddOpA  out  OPERAND_WIDTH  latched operand A to the adder.
- oAddOpB  out  OPERAND_WIDTH  latched operand B to the adder.
- iAddRes  in  OPERAND_WIDTH+1  adder oRes.
- iAddDone  in  1  adder oDone.
- oRspValid  out  1  response valid.
- oRspId  out  ID_W  ID of the requester being answered.
- oRspRes  out  OPERAND_WIDTH+1  sum (carry in MSB).
- iRspReady  in  1  response consumer ready.
- oTimeout  out  1  sticky watchdog flag.

Behaviour:
- Reset: one clock; reset is synchronous and active-low (iRstn sampled on posedge iClk).
  - While iRstn=0: state IDLE, round-robin pointer 0, watchdog 0.
  - All outputs 0: oGnt, oAddStart, oAddOpA/B, oRspValid, oRspId, oRspRes, oTimeout.
  - Reset mid-job abandons the job without a response.
  - Integration drives the adder's active-high iRst from ~iRstn so both reset together.
- All outputs are registered.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - If iReq != 0, pick the winner w = first set bit scanning upward from pointer rPtr, wrapping modulo N_REQ.
  - On that edge: latch iOpA/iOpB slice w into oAddOpA/oAddOpB, latch w into oRspId, set rPtr <= (w+1) mod N_REQ, go to START.
  - If iReq = 0, stay in IDLE.
- START:
  - oGnt[w]=1 and oAddStart=1 for exactly this cycle.
  - Clear the watchdog and go to WAIT.
  - The request is consumed at the IDLE->START edge. The requester must drop iReq or present new operands by the end of the oGnt cycle.
- WAIT:
  - oAddOpA/B are held stable for the whole job.
  - The watchdog increments every cycle.
  - On iAddDone=1: capture iAddRes into oRspRes and go to RESP.
  - If the watchdog reaches TIMEOUT_CYCLES-1 without done: set oTimeout=1 (sticky until reset), set oRspRes=0, go to RESP.
  - If done and timeout coincide, done wins and oTimeout is not set.
- RESP:
  - oRspValid=1; oRspId and oRspRes are held stable until iRspReady=1.
  - On the valid&&ready edge: oRspValid <= 0 and go to IDLE.
  - Requests arriving in RESP wait; arbitration happens only in IDLE.
- Throughput: at most one job in flight. Minimum issue-to-issue time is adder latency + 4 cycles.
- Fairness: a continuously requesting requester waits at most N_REQ-1 jobs.
- Ignored inputs: iAddDone outside WAIT is ignored. iReq bits outside IDLE are ignored.
- N_REQ=1: the pointer stays 0 and oRspId is always 0.

Decomposition:
- Package mp_arb_pkg holds:
  - state encodings (IDLE=2'd0, START=2'd1, WAIT=2'd2, RESP=2'd3);
  - a clog2-based ID_W helper;
  - the watchdog counter width derived from TIMEOUT_CYCLES.
- Sub-module rr_arbiter: combinational round-robin pick.
  - Inputs: req vector and pointer.
  - Outputs: any-valid, one-hot grant, encoded winner.
  - Reusable for other shared datapath resources.
- The top holds the FSM, operand/response registers and the watchdog.

Test Plan:
- Single request: iReq=4'b0010, A=2^512-1, B=1 -> oGnt=4'b0010 pulse, then oRspValid with oRspId=1 and oRspRes=2^512 (bit 512 set, rest 0). oTimeout stays 0.
- Round-robin with all four requesting continuously, operands A=i, B=10*i -> responses in order ID 0,1,2,3,0. Each oRspRes equals 11*i.
- Backpressure: iRspReady=0 for 20 cycles after oRspValid rises -> oRspValid, oRspId and oRspRes stay stable. No new oGnt or oAddStart until the cycle after ready=1.
- Timeout: adder model never asserts done -> after TIMEOUT_CYCLES (64) in WAIT: oTimeout=1, oRspValid=1, oRspRes=0. A following job with a working adder completes and oTimeout stays 1.
- Reset mid-job: drive iRstn=0 for one cycle during WAIT -> all outputs 0 next cycle, rPtr=0. A subsequent iReq=4'b1001 grants ID 0 first.
- Pointer wrap: grant to ID 3, then iReq=4'b1001 -> ID 0 granted next, then ID 3.
